// File: rtl/switch_debounce_bit.sv
// Single-bit debouncer: N-sample shift history, stable level and one-cycle edge pulses.
// The stable level flips only when the freshly shifted history is unanimous.
module switch_debounce_bit #(
    parameter int N = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_i,
    input  logic din_i,
    output logic out_o,
    output logic rise_o,
    output logic fall_o
);

    logic [N-1:0] hist_q;
    logic [N-1:0] hist_d;
    logic         out_q;
    logic         rise_q;
    logic         fall_q;

    always_comb begin
        hist_d = {hist_q[N-2:0], din_i};
    end

    // Decisions use the post-shift history so a change lands on the Nth agreeing sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            out_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (sample_i) begin
                hist_q <= hist_d;
                if ((&hist_d) && !out_q) begin
                    out_q  <= 1'b1;
                    rise_q <= 1'b1;
                end else if (!(|hist_d) && out_q) begin
                    out_q  <= 1'b0;
                    fall_q <= 1'b1;
                end
            end
        end
    end

    assign out_o  = out_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/switch_debounce_edge.sv
// Multi-bit switch debouncer with a shared sample-rate prescaler and per-bit edge pulses.
// One prescaler drives all WIDTH bit slices so every bit samples on the same clk edge.
module switch_debounce_edge #(
    parameter int WIDTH = 4,
    parameter int N     = 3,
    parameter int RATE  = 125000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             tick
);

    localparam int CNT_W = (RATE > 1) ? $clog2(RATE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             sample;

    assign sample = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = sample ? '0 : cnt_q + CNT_W'(1);
    end

    // tick is registered, so it rises on the same edge the bit slices consume the sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= sample;
        end
    end

    assign tick = tick_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .N(N)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .sample_i (sample),
            .din_i    (in[i]),
            .out_o    (out[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i])
        );
    end

endmodule

// File: tb/tb_switch_debounce_edge.sv
// Directed bench for switch_debounce_edge: one RATE=4/N=3 instance and one RATE=1/N=2 instance.
module tb_switch_debounce_edge;

    logic       clk;
    logic       rst;
    logic [3:0] in_a,  in_b;
    logic [3:0] out_a, rise_a, fall_a;
    logic [3:0] out_b, rise_b, fall_b;
    logic       tick_a, tick_b;

    int checks;
    int errors;

    switch_debounce_edge #(.WIDTH(4), .N(3), .RATE(4)) u_dut_a (
        .clk  (clk),
        .rst  (rst),
        .in   (in_a),
        .out  (out_a),
        .rise (rise_a),
        .fall (fall_a),
        .tick (tick_a)
    );

    switch_debounce_edge #(.WIDTH(4), .N(2), .RATE(1)) u_dut_b (
        .clk  (clk),
        .rst  (rst),
        .in   (in_b),
        .out  (out_b),
        .rise (rise_b),
        .fall (fall_b),
        .tick (tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        in_a   = 4'hF;
        in_b   = 4'hF;

        // Reset held 10 cycles with all inputs high.
        cyc(10);
        check("rst_out_a",  {28'h0, out_a},  32'h0);
        check("rst_rise_a", {28'h0, rise_a}, 32'h0);
        check("rst_fall_a", {28'h0, fall_a}, 32'h0);
        check("rst_tick_a", {31'h0, tick_a}, 32'h0);
        check("rst_out_b",  {28'h0, out_b},  32'h0);
        check("rst_tick_b", {31'h0, tick_b}, 32'h0);

        rst  = 1'b0;
        in_a = 4'h0;
        in_b = 4'h0;

        // First tick of the RATE=4 instance on the 4th edge after release.
        for (int k = 1; k <= 3; k++) begin
            cyc(1);
            check("tick_a_pre", {31'h0, tick_a}, 32'h0);
            check("tick_b_every", {31'h0, tick_b}, 32'h1);
        end
        cyc(1);                                     // edge 4
        check("tick_a_first", {31'h0, tick_a}, 32'h1);
        check("out_a_zero",   {28'h0, out_a},  32'h0);

        // Clean rising step on bit 0, applied right after a tick.
        in_a = 4'b0001;
        cyc(3);                                     // edge 7
        check("step_out_e7",  {28'h0, out_a},  32'h0);
        check("step_tick_e7", {31'h0, tick_a}, 32'h0);
        cyc(1);                                     // edge 8, 1st sample
        check("step_out_e8",  {28'h0, out_a},  32'h0);
        cyc(4);                                     // edge 12, 2nd sample
        check("step_out_e12", {28'h0, out_a},  32'h0);
        cyc(3);                                     // edge 15
        check("step_rise_e15", {28'h0, rise_a}, 32'h0);
        cyc(1);                                     // edge 16, 3rd sample
        check("step_out_e16",  {28'h0, out_a},  32'h1);
        check("step_rise_e16", {28'h0, rise_a}, 32'h1);
        check("step_fall_e16", {28'h0, fall_a}, 32'h0);
        check("step_tick_e16", {31'h0, tick_a}, 32'h1);
        cyc(1);                                     // edge 17
        check("step_rise_e17", {28'h0, rise_a}, 32'h0);
        check("step_out_e17",  {28'h0, out_a},  32'h1);

        // Glitch on bit 1 lasting two sample periods.
        in_a = 4'b0011;
        for (int k = 0; k < 8; k++) begin           // edges 18..25
            cyc(1);
            check("glitch_edges_hi", {24'h0, rise_a, fall_a}, 32'h0);
        end
        in_a = 4'b0001;
        for (int k = 0; k < 11; k++) begin          // edges 26..36
            cyc(1);
            check("glitch_edges_lo", {24'h0, rise_a, fall_a}, 32'h0);
        end
        check("glitch_out", {28'h0, out_a}, 32'h1);

        // Drive all high until out is all ones.
        in_a = 4'hF;
        cyc(11);                                    // edge 47
        check("all_hi_out_e47", {28'h0, out_a}, 32'h1);
        cyc(1);                                     // edge 48
        check("all_hi_out_e48",  {28'h0, out_a},  32'hF);
        check("all_hi_rise_e48", {28'h0, rise_a}, 32'hE);

        // Falling edges on bits 1 and 3 only.
        in_a = 4'b0101;
        cyc(11);                                    // edge 59
        check("fall_out_e59", {28'h0, out_a}, 32'hF);
        cyc(1);                                     // edge 60
        check("fall_out_e60",  {28'h0, out_a},  32'h5);
        check("fall_fall_e60", {28'h0, fall_a}, 32'hA);
        check("fall_rise_e60", {28'h0, rise_a}, 32'h0);
        cyc(1);                                     // edge 61
        check("fall_fall_e61", {28'h0, fall_a}, 32'h0);

        // Two of three zero samples on bit 2, then asynchronous reset mid-cycle.
        in_a = 4'b0001;
        cyc(8);                                     // edge 69, samples at 64 and 68
        check("arst_out_before", {28'h0, out_a}, 32'h5);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_async",  {28'h0, out_a},  32'h0);
        check("arst_tick_async", {31'h0, tick_a}, 32'h0);
        cyc(2);
        rst  = 1'b0;
        in_a = 4'b0101;
        cyc(4);                                     // edge 4 after release, 1st fresh sample
        check("arst_tick_first", {31'h0, tick_a}, 32'h1);
        check("arst_out_e4",     {28'h0, out_a},  32'h0);
        cyc(7);                                     // edge 11
        check("arst_out_e11", {28'h0, out_a}, 32'h0);
        cyc(1);                                     // edge 12, 3rd fresh sample
        check("arst_out_e12",  {28'h0, out_a},  32'h5);
        check("arst_rise_e12", {28'h0, rise_a}, 32'h5);

        // RATE=1, N=2: toggle bit 3 each cycle, then hold.
        in_b = 4'b1000;
        cyc(1);
        check("b_toggle1_out", {28'h0, out_b}, 32'h0);
        check("b_tick1",       {31'h0, tick_b}, 32'h1);
        in_b = 4'b0000;
        cyc(1);
        check("b_toggle2_out", {28'h0, out_b}, 32'h0);
        in_b = 4'b1000;
        cyc(1);
        check("b_toggle3_out", {28'h0, out_b}, 32'h0);
        in_b = 4'b0000;
        cyc(1);
        check("b_toggle4_out", {28'h0, out_b}, 32'h0);
        check("b_toggle4_edges", {24'h0, rise_b, fall_b}, 32'h0);
        in_b = 4'b1000;
        cyc(1);
        check("b_hold1_out", {28'h0, out_b}, 32'h0);
        cyc(1);
        check("b_hold2_out",  {28'h0, out_b},  32'h8);
        check("b_hold2_rise", {28'h0, rise_b}, 32'h8);
        check("b_tick_hold2", {31'h0, tick_b}, 32'h1);
        cyc(1);
        check("b_hold3_rise", {28'h0, rise_b}, 32'h0);
        in_b = 4'b0000;
        cyc(1);
        check("b_low1_out", {28'h0, out_b}, 32'h8);
        cyc(1);
        check("b_low2_out",  {28'h0, out_b},  32'h0);
        check("b_low2_fall", {28'h0, fall_b}, 32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
